// File: rtl/hacd_pkg.sv
// hacd_pkg: shared widths, page geometry and debug types for the HACD page engines
`ifndef HACD_AXI4_DATA_WIDTH
`define HACD_AXI4_DATA_WIDTH 512
`endif
package hacd_pkg;
  localparam int HACD_DATA_WIDTH = `HACD_AXI4_DATA_WIDTH;
  localparam int HACD_LINES_PER_PAGE = 64;
  localparam int HACD_LINES_PER_CHUNK = 16;
  localparam int HACD_META_VEC_W = 4;
  localparam int HACD_MIN_ZERO_CHUNKS = 3;
  typedef enum logic [2:0] {
    DS_IDLE, DS_RD_META, DS_CHECK_META, DS_EXPAND, DS_DONE, DS_BUS_ERROR
  } decomp_state_e;
  typedef struct packed {
    logic [2:0] state;
    logic [6:0] out_cnt;
    logic [HACD_META_VEC_W-1:0] zero_chunk_vec;
    logic [1:0] data_chunk;
    logic hold_vld;
  } debug_decompressor;
  // the stored chunk is the lowest non-zero one; an all-zero page keeps its lines in chunk 0
  function automatic logic [1:0] first_data_chunk(input logic [HACD_META_VEC_W-1:0] vec);
    return !vec[0] ? 2'd0 : !vec[1] ? 2'd1 : !vec[2] ? 2'd2 : !vec[3] ? 2'd3 : 2'd0;
  endfunction
endpackage

// File: rtl/hacd_decompressor.sv
// hacd_decompressor: expands a metadata line plus one stored chunk back into a 64-line page
module hacd_decompressor
  import hacd_pkg::*;
#(
  parameter int DATA_WIDTH = HACD_DATA_WIDTH,
  parameter int LINES_PER_PAGE = HACD_LINES_PER_PAGE,
  parameter int LINES_PER_CHUNK = HACD_LINES_PER_CHUNK,
  parameter int MIN_ZERO_CHUNKS = HACD_MIN_ZERO_CHUNKS
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic decomp_start,
  input  logic rdfifo_empty,
  output logic rd_req,
  input  logic [DATA_WIDTH-1:0] rd_data,
  input  logic [1:0] rd_rresp,
  input  logic rd_valid,
  input  logic wrfifo_full,
  output logic wr_req,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic decomp_done,
  output logic meta_err,
  output logic bus_err,
  output debug_decompressor debug_decomp
);
  localparam logic [2:0] IDLE = DS_IDLE;
  localparam logic [2:0] RD_META = DS_RD_META;
  localparam logic [2:0] CHECK_META = DS_CHECK_META;
  localparam logic [2:0] EXPAND = DS_EXPAND;
  localparam logic [2:0] DONE = DS_DONE;
  localparam logic [2:0] BUS_ERROR = DS_BUS_ERROR;
  logic [2:0] state;
  logic [6:0] out_cnt;
  logic [3:0] vec;
  logic [1:0] data_chunk;
  logic meta_hi;
  logic [DATA_WIDTH-1:0] hold;
  logic hold_vld;
  logic rd_pend;
  logic rd_ok;
  logic rresp_bad;
  logic zero_line;
  logic meta_bad;
  logic need_rd;
  assign rd_ok = rd_valid && rd_pend;
  assign rresp_bad = rd_rresp != 2'd0;
  assign zero_line = 2'(out_cnt / 7'(LINES_PER_CHUNK)) != data_chunk;
  assign meta_bad = meta_hi || $countones(vec) < MIN_ZERO_CHUNKS;
  assign need_rd = state == RD_META || (state == EXPAND && !zero_line && !hold_vld);
  assign rd_req = need_rd && !rd_pend && !rdfifo_empty;
  // the hold register is cleared on every push, so it doubles as the zero line source
  assign wr_req = state == EXPAND && (zero_line || hold_vld) && !wrfifo_full;
  assign wr_data = hold;
  assign decomp_done = state == DONE;
  assign meta_err = state == CHECK_META && meta_bad;
  assign bus_err = state == BUS_ERROR;
  assign debug_decomp = '{state: state, out_cnt: out_cnt, zero_chunk_vec: vec,
                          data_chunk: data_chunk, hold_vld: hold_vld};
  // page FSM, single outstanding read tracking and the one-line hold register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
      out_cnt <= '0;
      vec <= '0;
      data_chunk <= '0;
      meta_hi <= 1'b0;
      hold <= '0;
      hold_vld <= 1'b0;
      rd_pend <= 1'b0;
    end else begin
      rd_pend <= rd_req ? 1'b1 : rd_ok ? 1'b0 : rd_pend;
      case (state)
        IDLE: if (decomp_start && !rdfifo_empty) begin
          out_cnt <= '0;
          vec <= '0;
          data_chunk <= '0;
          state <= RD_META;
        end
        RD_META: if (rd_ok) begin
          vec <= rd_data[3:0];
          meta_hi <= |rd_data[DATA_WIDTH-1:4];
          state <= rresp_bad ? BUS_ERROR : CHECK_META;
        end
        CHECK_META: begin
          data_chunk <= first_data_chunk(vec);
          out_cnt <= '0;
          state <= meta_bad ? IDLE : EXPAND;
        end
        EXPAND: begin
          if (rd_ok && rresp_bad) state <= BUS_ERROR;
          else if (rd_ok) begin
            hold <= rd_data;
            hold_vld <= 1'b1;
          end
          if (wr_req) begin
            hold <= '0;
            hold_vld <= 1'b0;
            out_cnt <= out_cnt + 7'd1;
            if (out_cnt == 7'(LINES_PER_PAGE - 1)) state <= DONE;
          end
        end
        DONE: if (!decomp_start) state <= IDLE;
        BUS_ERROR: state <= BUS_ERROR;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_hacd_decompressor.sv
// tb_hacd_decompressor: random pages against a FIFO environment and a page-level reference model
module tb_hacd_decompressor;
  import hacd_pkg::*;
  typedef struct {
    logic [511:0] d;
    logic [1:0] r;
  } rd_ent_t;
  logic clk = 1'b0;
  logic rst_i = 1'b1;
  logic decomp_start = 1'b0;
  logic rdfifo_empty = 1'b1;
  logic rd_req;
  logic [511:0] rd_data = '0;
  logic [1:0] rd_rresp = 2'd0;
  logic rd_valid = 1'b0;
  logic wrfifo_full = 1'b0;
  logic wr_req;
  logic [511:0] wr_data;
  logic decomp_done;
  logic meta_err;
  logic bus_err;
  debug_decompressor debug_decomp;
  int vectors = 0;
  int miscompares = 0;
  rd_ent_t rq[$];
  rd_ent_t cur;
  logic [511:0] outq[$];
  int push_cyc[$];
  logic [511:0] exp_d[16];
  int n_rd = 0, n_meta = 0, proto = 0, cyc_now = 0;
  bit rd_busy = 0;
  int rd_delay = 0;
  bit bp_en = 0;
  int lat_max = 1;

  hacd_decompressor dut (
    .clk_i(clk), .rst_i(rst_i), .decomp_start(decomp_start), .rdfifo_empty(rdfifo_empty),
    .rd_req(rd_req), .rd_data(rd_data), .rd_rresp(rd_rresp), .rd_valid(rd_valid),
    .wrfifo_full(wrfifo_full), .wr_req(wr_req), .wr_data(wr_data), .decomp_done(decomp_done),
    .meta_err(meta_err), .bus_err(bus_err), .debug_decomp(debug_decomp)
  );

  initial forever #5 clk = ~clk;

  // read/write FIFO environment: inputs change on the falling edge, requests sampled 1 ns later
  initial forever begin
    @(negedge clk);
    cyc_now++;
    rd_valid = 1'b0;
    if (rst_i) rd_busy = 0;
    if (rd_busy) begin
      rd_delay--;
      if (rd_delay == 0) begin
        rd_valid = 1'b1;
        rd_data = cur.d;
        rd_rresp = cur.r;
        rd_busy = 0;
      end
    end
    rdfifo_empty = rq.size() == 0;
    wrfifo_full = bp_en && $urandom_range(0, 1) == 1;
    #1;
    if (rd_req) begin
      n_rd++;
      if (rd_busy || rd_valid || rq.size() == 0) proto++;
      if (rq.size() != 0) begin
        cur = rq.pop_front();
        rd_busy = 1;
        rd_delay = $urandom_range(1, lat_max);
      end
    end
    if (wr_req) begin
      if (wrfifo_full) proto++;
      outq.push_back(wr_data);
      push_cyc.push_back(cyc_now);
    end
    if (meta_err) n_meta++;
  end

  function automatic int stored_chunk(input logic [3:0] v);
    for (int b = 0; b < 4; b++) if (!v[b]) return b;
    return 0;
  endfunction

  function automatic logic [511:0] exp_line(input logic [3:0] v, input int i);
    return (i / 16 == stored_chunk(v)) ? exp_d[i % 16] : 512'd0;
  endfunction

  function automatic logic [3:0] rand_legal();
    logic [3:0] v;
    do v = 4'($urandom_range(0, 15)); while ($countones(v) < 3);
    return v;
  endfunction

  task automatic apply_reset();
    decomp_start = 1'b0;
    @(negedge clk);
    #2;
    rst_i = 1'b1;
    rq.delete();
    outq.delete();
    push_cyc.delete();
    n_rd = 0;
    n_meta = 0;
    proto = 0;
    repeat (2) @(negedge clk);
    #2;
    rst_i = 1'b0;
  endtask

  task automatic load_page(input logic [3:0] v, input bit hi, input int err_at, input bit with_data);
    rd_ent_t e;
    e.d = '0;
    e.d[3:0] = v;
    if (hi) e.d[100] = 1'b1;
    e.r = 2'd0;
    rq.push_back(e);
    for (int k = 0; k < 16; k++) begin
      for (int w = 0; w < 16; w++) exp_d[k][w*32 +: 32] = $urandom;
      e.d = exp_d[k];
      e.r = (k == err_at) ? 2'd2 : 2'd0;
      if (with_data) rq.push_back(e);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    #2;
    vectors++;
    if ({rd_req, wr_req, decomp_done, meta_err, bus_err} !== 5'b0) begin
      miscompares++;
      $display("FAIL reset_ctrl: rd_req/wr_req/done/meta_err/bus_err=%b required 00000",
               {rd_req, wr_req, decomp_done, meta_err, bus_err});
    end
    vectors++;
    if (wr_data !== '0) begin miscompares++; $display("FAIL reset_wr_data: got %h required 0", wr_data); end
    vectors++;
    if (debug_decomp.state !== 3'd0 || debug_decomp.out_cnt !== 7'd0 || debug_decomp.hold_vld !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_debug: state=%0d out_cnt=%0d hold_vld=%b required 0/0/0",
               debug_decomp.state, debug_decomp.out_cnt, debug_decomp.hold_vld);
    end
    rst_i = 1'b0;
  endtask

  task automatic test_page(input logic [3:0] v, input bit bp, input int lat, input string nm);
    int cyc, bad, gb;
    apply_reset();
    bp_en = bp;
    lat_max = lat;
    load_page(v, 0, -1, 1);
    decomp_start = 1'b1;
    cyc = 0;
    while (!decomp_done && cyc < 3000) begin @(negedge clk); #2; cyc++; end
    vectors++;
    if (decomp_done !== 1'b1) begin miscompares++; $display("FAIL %s_done_timeout: done=%b after %0d cycles, required 1", nm, decomp_done, cyc); end
    vectors++;
    if (outq.size() != 64) begin miscompares++; $display("FAIL %s_line_count: got %0d required 64", nm, outq.size()); end
    bad = 0;
    for (int i = 0; i < outq.size() && i < 64; i++) if (outq[i] !== exp_line(v, i)) bad++;
    vectors++;
    if (bad != 0) begin miscompares++; $display("FAIL %s_lines vec=%b: %0d wrong lines, required 0", nm, v, bad); end
    vectors++;
    if (n_rd != 17 || proto != 0) begin miscompares++; $display("FAIL %s_reads: rd_req=%0d protocol_errors=%0d required 17/0", nm, n_rd, proto); end
    repeat (5) @(negedge clk);
    #2;
    vectors++;
    if (decomp_done !== 1'b1) begin miscompares++; $display("FAIL %s_done_hold: done=%b required 1", nm, decomp_done); end
    decomp_start = 1'b0;
    @(negedge clk);
    #2;
    vectors++;
    if (decomp_done !== 1'b0 || debug_decomp.state !== 3'd0) begin
      miscompares++;
      $display("FAIL %s_done_release: done=%b state=%0d required 0/0", nm, decomp_done, debug_decomp.state);
    end
    if (!bp && lat == 1) begin
      gb = 0;
      if (push_cyc.size() < 64) gb = 64;
      else for (int i = 1; i < 64; i++)
        if (push_cyc[i] - push_cyc[i-1] != ((i / 16 == stored_chunk(v)) ? 3 : 1)) gb++;
      vectors++;
      if (gb != 0) begin miscompares++; $display("FAIL %s_rate: %0d pushes off the 1/3-cycle cadence, required 0", nm, gb); end
    end
  endtask

  task automatic test_meta_err(input logic [3:0] v, input bit hi, input string nm);
    int cyc;
    apply_reset();
    bp_en = 0;
    lat_max = 1;
    load_page(v, hi, -1, 0);
    decomp_start = 1'b1;
    cyc = 0;
    while (n_meta == 0 && cyc < 200) begin @(negedge clk); #2; cyc++; end
    decomp_start = 1'b0;
    repeat (10) @(negedge clk);
    #2;
    vectors++;
    if (n_meta != 1) begin miscompares++; $display("FAIL %s_meta_err vec=%b: pulses=%0d required 1", nm, v, n_meta); end
    vectors++;
    if (n_rd != 1 || outq.size() != 0) begin miscompares++; $display("FAIL %s_traffic: rd_req=%0d wr_req=%0d required 1/0", nm, n_rd, outq.size()); end
    vectors++;
    if (debug_decomp.state !== 3'd0 || bus_err !== 1'b0) begin
      miscompares++;
      $display("FAIL %s_idle: state=%0d bus_err=%b required 0/0", nm, debug_decomp.state, bus_err);
    end
  endtask

  task automatic test_backpressure();
    for (int p = 0; p < 3; p++) test_page(rand_legal(), 1, 4, "bp");
  endtask

  task automatic test_bus_err();
    int cyc, bad;
    apply_reset();
    bp_en = 1;
    lat_max = 2;
    load_page(4'b1011, 0, 4, 1);
    decomp_start = 1'b1;
    cyc = 0;
    while (!bus_err && cyc < 2000) begin @(negedge clk); #2; cyc++; end
    repeat (20) @(negedge clk);
    #2;
    vectors++;
    if (bus_err !== 1'b1) begin miscompares++; $display("FAIL bus_err_sticky: got %b required 1", bus_err); end
    vectors++;
    if (n_rd != 6 || outq.size() != 36) begin miscompares++; $display("FAIL bus_err_traffic: rd_req=%0d wr_req=%0d required 6/36", n_rd, outq.size()); end
    bad = 0;
    for (int i = 0; i < outq.size() && i < 36; i++) if (outq[i] !== exp_line(4'b1011, i)) bad++;
    vectors++;
    if (bad != 0) begin miscompares++; $display("FAIL bus_err_lines: %0d wrong lines, required 0", bad); end
    vectors++;
    if (rd_req !== 1'b0 || wr_req !== 1'b0 || proto != 0) begin
      miscompares++;
      $display("FAIL bus_err_quiet: rd_req=%b wr_req=%b protocol_errors=%0d required 0/0/0", rd_req, wr_req, proto);
    end
  endtask

  task automatic test_rst_mid_expand();
    int cyc;
    apply_reset();
    bp_en = 0;
    lat_max = 1;
    load_page(4'b1110, 0, -1, 1);
    decomp_start = 1'b1;
    cyc = 0;
    while (!(debug_decomp.state == 3'd3 && debug_decomp.hold_vld && debug_decomp.out_cnt >= 7'd3) && cyc < 500) begin
      @(negedge clk);
      #2;
      cyc++;
    end
    vectors++;
    if (wr_req !== 1'b1 || wr_data !== exp_d[debug_decomp.out_cnt[3:0]]) begin
      miscompares++;
      $display("FAIL rst_mid_precondition: wr_req=%b after %0d cycles, required 1 with stored line", wr_req, cyc);
    end
    decomp_start = 1'b0;
    rst_i = 1'b1;
    #1;
    vectors++;
    if ({rd_req, wr_req, decomp_done, meta_err, bus_err} !== 5'b0 || wr_data !== '0) begin
      miscompares++;
      $display("FAIL rst_mid_outputs: ctrl=%b wr_data_nonzero=%b required 00000/0",
               {rd_req, wr_req, decomp_done, meta_err, bus_err}, wr_data !== '0);
    end
    vectors++;
    if (debug_decomp.state !== 3'd0 || debug_decomp.out_cnt !== 7'd0 || debug_decomp.hold_vld !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_mid_state: state=%0d out_cnt=%0d hold_vld=%b required 0/0/0",
               debug_decomp.state, debug_decomp.out_cnt, debug_decomp.hold_vld);
    end
    @(negedge clk);
    #2;
    rst_i = 1'b0;
  endtask

  initial begin
    logic [3:0] bad_vec;
    test_reset();
    test_page(4'b1110, 0, 1, "vec_e");
    test_page(4'b1011, 0, 1, "vec_b");
    test_page(4'hF, 0, 1, "vec_f");
    test_page(rand_legal(), 0, 1, "vec_rand");
    test_meta_err(4'b0011, 0, "vec_3");
    test_meta_err(4'b1110, 1, "bit100");
    do bad_vec = 4'($urandom_range(0, 15)); while ($countones(bad_vec) >= 3);
    test_meta_err(bad_vec, 0, "rand_illegal");
    test_backpressure();
    test_bus_err();
    test_rst_mid_expand();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
